// File: rtl/imm_gen_stage.sv
// Immediate-generation decode stage: decodes one instruction per cycle into
// format/immediate/illegal and buffers the results in an in-order queue.
module imm_gen_stage #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 2,
    parameter bit ENABLE_ZICSR = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int SHW = (XLEN == 64) ? 6 : 5;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z, FMT_ILL
    } fmt_t;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
        logic [XLEN-1:0] pc;
    } entry_t;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_stage: XLEN must be 32 or 64");
        end
    endgenerate

    // ---------------- decode ----------------
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic            is_shift;
    logic [XLEN-1:0] i_imm;
    logic [XLEN-1:0] imm;
    fmt_t            fmt;
    entry_t          dec;

    always_comb begin
        opcode   = in_instr[6:0];
        f3       = in_instr[14:12];
        is_shift = (f3 == 3'b001) || (f3 == 3'b101);
        i_imm    = XLEN'($signed(in_instr[31:20]));
        fmt      = FMT_ILL;
        imm      = '0;
        case (opcode)
            7'b0000011, 7'b0001111, 7'b1100111: begin
                fmt = FMT_I;
                imm = i_imm;
            end
            7'b0010011: begin
                fmt = FMT_I;
                imm = is_shift ? XLEN'(in_instr[20 +: SHW]) : i_imm;
            end
            7'b0011011: begin
                // word-sized shifts always use a 5-bit shamt
                if (XLEN == 64) begin
                    fmt = FMT_I;
                    imm = is_shift ? XLEN'(in_instr[24:20]) : i_imm;
                end
            end
            7'b0100011: begin
                fmt = FMT_S;
                imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            end
            7'b1100011: begin
                fmt = FMT_B;
                imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                     in_instr[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                fmt = FMT_U;
                imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            end
            7'b1101111: begin
                fmt = FMT_J;
                imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                     in_instr[30:21], 1'b0}));
            end
            7'b1110011: begin
                if (f3[2]) begin
                    if (ENABLE_ZICSR) begin
                        fmt = FMT_Z;
                        imm = XLEN'(in_instr[19:15]);
                    end
                end else begin
                    fmt = FMT_I;
                    imm = i_imm;
                end
            end
            7'b0110011: fmt = FMT_R;
            7'b0111011: if (XLEN == 64) fmt = FMT_R;
            default: fmt = FMT_ILL;
        endcase
        dec.imm = imm;
        dec.fmt = fmt;
        dec.ill = (fmt == FMT_ILL);
        dec.pc  = in_pc;
    end

    // ---------------- queue ----------------
    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            rdy_q;
    logic            push, pop;
    entry_t          head;

    // rdy_q keeps in_ready low while reset is held, without touching count
    assign in_ready  = rdy_q && (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= dec;
    end

    assign head        = mem[rd_ptr];
    assign out_imm     = out_valid ? head.imm : '0;
    assign out_fmt     = out_valid ? head.fmt : '0;
    assign out_illegal = out_valid ? head.ill : 1'b0;
    assign out_pc      = out_valid ? head.pc  : '0;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: directed vectors plus random traffic scored against
// a queue-based reference model; a second XLEN=64 instance covers RV64 decode.
module tb_imm_gen_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance A: XLEN=32, DEPTH=2, Zicsr on
    logic        flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_instr = 0, in_pc = 0;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm, out_pc;
    logic [2:0]  out_fmt;

    // instance B: XLEN=64, DEPTH=3, Zicsr off
    logic        b_flush = 0, b_in_valid = 0, b_out_ready = 1;
    logic [31:0] b_in_instr = 0;
    logic [63:0] b_in_pc = 0;
    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm, b_out_pc;
    logic [2:0]  b_out_fmt;

    imm_gen_stage #(.XLEN(32), .DEPTH(2), .ENABLE_ZICSR(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_pc(out_pc));

    imm_gen_stage #(.XLEN(64), .DEPTH(3), .ENABLE_ZICSR(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_pc(b_in_pc), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal), .out_pc(b_out_pc));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } dec_t;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [63:0] pc;
    } ment_t;

    ment_t mq[$];
    bit    model_rdy = 0;
    localparam int ADEPTH = 2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode built directly from the field tables with 64-bit arithmetic.
    function automatic dec_t ref_dec(input logic [31:0] i, input bit x64, input bit zicsr);
        dec_t        d;
        longint      s, hi;
        logic [63:0] u;
        logic [2:0]  f3;
        s = $signed(i);
        u = {32'b0, i};
        f3 = i[14:12];
        d.imm = 0;
        d.fmt = 7;
        case (i[6:0])
            7'h03, 7'h0F, 7'h67: begin d.fmt = 1; d.imm = s >>> 20; end
            7'h13: begin
                d.fmt = 1;
                if (f3 == 1 || f3 == 5) d.imm = (u >> 20) & (x64 ? 64'd63 : 64'd31);
                else d.imm = s >>> 20;
            end
            7'h1B: if (x64) begin
                d.fmt = 1;
                if (f3 == 1 || f3 == 5) d.imm = (u >> 20) & 64'd31;
                else d.imm = s >>> 20;
            end
            7'h23: begin
                d.fmt = 2; hi = s >>> 25;
                d.imm = (hi << 5) | ((u >> 7) & 64'd31);
            end
            7'h63: begin
                d.fmt = 3; hi = s >>> 31;
                d.imm = (hi << 12) | (((u >> 7) & 64'd1) << 11) |
                        (((u >> 25) & 64'd63) << 5) | (((u >> 8) & 64'd15) << 1);
            end
            7'h37, 7'h17: begin d.fmt = 4; hi = s >>> 12; d.imm = hi << 12; end
            7'h6F: begin
                d.fmt = 5; hi = s >>> 31;
                d.imm = (hi << 20) | (((u >> 12) & 64'd255) << 12) |
                        (((u >> 20) & 64'd1) << 11) | (((u >> 21) & 64'd1023) << 1);
            end
            7'h73: begin
                if (f3 >= 4) begin
                    if (zicsr) begin d.fmt = 6; d.imm = (u >> 15) & 64'd31; end
                end else begin
                    d.fmt = 1; d.imm = s >>> 20;
                end
            end
            7'h33: d.fmt = 0;
            7'h3B: if (x64) d.fmt = 0;
            default: d.fmt = 7;
        endcase
        d.ill = (d.fmt == 7);
        if (!x64) d.imm = {32'b0, d.imm[31:0]};
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [15];
        logic [31:0] r;
        int          k;
        ops = '{7'h03, 7'h0F, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37,
                7'h17, 7'h6F, 7'h73, 7'h33, 7'h3B, 7'h7F, 7'h00};
        r = $urandom;
        k = $urandom_range(0, 15);
        if (k == 15) return r;
        return {r[31:7], ops[k]};
    endfunction

    // One clock of instance A: score outputs, drive inputs, then advance the model.
    task automatic cyc(input bit v, input logic [31:0] ins, input bit ordy, input bit fl,
                       input bit ce = 0, input logic [63:0] cimm = 0,
                       input logic [2:0] cfmt = 0, input bit cill = 0);
        logic [31:0] pcv;
        bit          push, pop;
        dec_t        d;
        ment_t       e;
        pcv = $urandom;
        @(negedge clk);
        chk("in_ready", in_ready, model_rdy && (mq.size() < ADEPTH));
        chk("out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("out_imm", out_imm, mq[0].imm);
            chk("out_fmt", out_fmt, mq[0].fmt);
            chk("out_illegal", out_illegal, mq[0].ill);
            chk("out_pc", out_pc, mq[0].pc);
        end else begin
            chk("empty_imm", out_imm, 0);
            chk("empty_fmt", out_fmt, 0);
            chk("empty_pc", out_pc, 0);
        end
        if (ce) begin
            chk("vec_imm", out_imm, cimm);
            chk("vec_fmt", out_fmt, cfmt);
            chk("vec_ill", out_illegal, cill);
        end
        in_valid = v; in_instr = ins; in_pc = pcv; out_ready = ordy; flush = fl;
        push = v && model_rdy && (mq.size() < ADEPTH);
        pop  = (mq.size() > 0) && ordy;
        d = ref_dec(ins, 0, 1);
        e.imm = d.imm; e.fmt = d.fmt; e.ill = d.ill; e.pc = {32'b0, pcv};
        @(posedge clk);
        if (fl) mq.delete();
        else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
        model_rdy = 1;
    endtask

    // Push one instruction into instance B and check it one cycle later.
    task automatic bpush(input string tag, input logic [31:0] ins, input logic [63:0] cimm,
                         input logic [2:0] cfmt, input bit cill);
        dec_t        d;
        logic [63:0] pcv;
        pcv = {$urandom, $urandom};
        @(negedge clk);
        b_in_valid = 1; b_in_instr = ins; b_in_pc = pcv;
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 0;
        d = ref_dec(ins, 1, 0);
        chk({tag, "_valid"}, b_out_valid, 1);
        chk({tag, "_imm"}, b_out_imm, cimm);
        chk({tag, "_fmt"}, b_out_fmt, cfmt);
        chk({tag, "_ill"}, b_out_illegal, cill);
        chk({tag, "_pc"}, b_out_pc, pcv);
        chk({tag, "_model"}, b_out_imm, d.imm);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_fmt", out_fmt, 0);
        chk("rst_ill", out_illegal, 0);
        chk("rst_pc", out_pc, 0);
        rst_n = 1;
        @(posedge clk);
        model_rdy = 1;

        // directed vectors, each checked as a constant the following cycle
        cyc(1, 32'hFFF00093, 1, 0);
        cyc(1, 32'hFE000EE3, 1, 0, 1, 64'hFFFFFFFF, 3'd1, 0);
        cyc(1, 32'h0040006F, 1, 0, 1, 64'hFFFFFFFC, 3'd3, 0);
        cyc(1, 32'h4030D093, 1, 0, 1, 64'h4, 3'd5, 0);
        cyc(1, 32'h0000007F, 1, 0, 1, 64'h3, 3'd1, 0);
        cyc(1, 32'h0000101B, 1, 0, 1, 64'h0, 3'd7, 1);
        cyc(0, 32'h0, 1, 0, 1, 64'h0, 3'd7, 1);

        // fill with consumer stalled; third push must be refused
        cyc(1, rand_instr(), 0, 0);
        cyc(1, rand_instr(), 0, 0);
        cyc(1, rand_instr(), 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);

        // flush while full with a push in the same cycle
        cyc(1, rand_instr(), 0, 0);
        cyc(1, rand_instr(), 0, 0);
        cyc(1, 32'h00500093, 0, 1);
        cyc(0, 0, 0, 0);

        // random traffic
        for (int n = 0; n < 600; n++)
            cyc(($urandom % 4) != 0, rand_instr(), ($urandom % 3) != 0, ($urandom % 25) == 0);

        // reset mid-stream with the queue holding data
        cyc(1, rand_instr(), 0, 0);
        cyc(1, rand_instr(), 0, 0);
        @(negedge clk);
        rst_n = 0;
        in_valid = 0; flush = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_imm", out_imm, 0);
        chk("mid_rst_fmt", out_fmt, 0);
        chk("mid_rst_pc", out_pc, 0);
        chk("mid_rst_ready", in_ready, 0);
        mq.delete();
        model_rdy = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        model_rdy = 1;
        cyc(1, rand_instr(), 1, 0);
        cyc(0, 0, 1, 0);

        // RV64 instance: sign-extended U, 6-bit shamt, word ops, Zicsr disabled
        bpush("b_lui",   32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 0);
        bpush("b_srai",  32'h4230D093, 64'h23, 3'd1, 0);
        bpush("b_slliw", 32'h0030909B, 64'h3, 3'd1, 0);
        bpush("b_addiw", 32'hFFF0809B, 64'hFFFFFFFFFFFFFFFF, 3'd1, 0);
        bpush("b_csrwi", 32'h3400D073, 64'h0, 3'd7, 1);
        bpush("b_op32",  32'h0000003B, 64'h0, 3'd0, 0);
        bpush("b_jal",   32'h0040006F, 64'h4, 3'd5, 0);
        for (int n = 0; n < 40; n++) begin : b_rand
            logic [31:0] ri;
            dec_t        rd;
            ri = rand_instr();
            rd = ref_dec(ri, 1, 0);
            bpush("b_rand", ri, rd.imm, rd.fmt, rd.ill);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
